// File: rtl/gf151_inverse.sv
// -----------------------------------------------------------------------------
// gf151_inverse
//
// Multiplicative inverse over GF(151) computed as a^149 mod 151 (Fermat),
// using left-to-right square-and-multiply with one 8x8 modular multiply per
// cycle. The exponent is fixed, so every element takes exactly 7 squares and
// 3 multiplies.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   din_valid   input element valid
//   din_ready   block can accept an input (high only in IDLE)
//   din_a       input element, 0..255 (values >= 151 are folded once)
//   dout_valid  result valid (high only in DONE)
//   dout_ready  consumer accepts the result
//   dout_r      inverse, 0..150 (0 for a zero element)
//   dout_err    self-check failure flag (only with GF151_INV_CHECK_EN)
//
// Optional feature macro: GF151_INV_CHECK_EN
//   Adds a CHK cycle that multiplies the result back by the element and
//   raises dout_err when the product is not 1.
// -----------------------------------------------------------------------------

// Barrett reduction mod 151 for a 15-bit operand.
// m = floor(2^16 / 151) = 434; the quotient estimate is at most one short,
// so a single conditional subtract completes the reduction.
module barret_for_151 (
    input  logic [14:0] x_i,
    output logic [7:0]  r_o
);
    logic [7:0] q;
    logic [8:0] rem;

    always_comb begin
        q   = 8'(({9'd0, x_i} * 24'd434) >> 16);
        rem = 9'({1'b0, x_i} - (16'(q) * 16'd151));
        r_o = (rem >= 9'd151) ? 8'(rem - 9'd151) : rem[7:0];
    end
endmodule

module gf151_inverse (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic [7:0] din_a,
    output logic       dout_valid,
    input  logic       dout_ready,
`ifdef GF151_INV_CHECK_EN
    output logic       dout_err,
`endif
    output logic [7:0] dout_r
);
    // 149 = 1001_0101; bit 7 is consumed by loading r = a.
    localparam logic [7:0] EXP = 8'b1001_0101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQR  = 3'd1,
        MUL  = 3'd2,
`ifdef GF151_INV_CHECK_EN
        CHK  = 3'd3,
`endif
        DONE = 3'd4
    } state_t;

`ifdef GF151_INV_CHECK_EN
    localparam state_t LAST = CHK;
`else
    localparam state_t LAST = DONE;
`endif

    state_t      state_q, state_d;
    logic [7:0]  a_q, r_q, dout_r_q;
    logic [2:0]  idx_q;
    logic [7:0]  a_in, op_b, red;
    logic [14:0] prod;
`ifdef GF151_INV_CHECK_EN
    logic        err_q;
`endif

    // Single fold brings 0..255 into 0..150.
    assign a_in = (din_a >= 8'd151) ? (din_a - 8'd151) : din_a;

    // Squaring uses r as both operands; MUL and CHK multiply r by a.
    assign op_b = (state_q == SQR) ? r_q : a_q;
    assign prod = {7'd0, r_q} * {7'd0, op_b};

    barret_for_151 u_red (
        .x_i (prod),
        .r_o (red)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: walk the exponent bits from index 6 down to 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (din_valid) state_d = SQR;
            SQR: begin
                if (EXP[idx_q])          state_d = MUL;
                else if (idx_q == 3'd0)  state_d = LAST;
                else                     state_d = SQR;
            end
            MUL: state_d = (idx_q == 3'd0) ? LAST : SQR;
`ifdef GF151_INV_CHECK_EN
            CHK: state_d = DONE;
`endif
            DONE: if (dout_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: the output register is only written on the edge entering
    // DONE, so dout_r stays stable through the whole computation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            r_q      <= '0;
            idx_q    <= '0;
            dout_r_q <= '0;
`ifdef GF151_INV_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (din_valid) begin
                    a_q   <= a_in;
                    r_q   <= a_in;
                    idx_q <= 3'd6;
                end
                SQR: begin
                    r_q <= red;
                    if (!EXP[idx_q] && idx_q != 3'd0) idx_q <= idx_q - 3'd1;
                end
                MUL: begin
                    r_q <= red;
                    if (idx_q != 3'd0) idx_q <= idx_q - 3'd1;
                end
                default: ;
            endcase
            if (state_d == DONE && state_q != DONE) begin
`ifdef GF151_INV_CHECK_EN
                dout_r_q <= r_q;
                err_q    <= (red != 8'd1);
`else
                dout_r_q <= red;
`endif
            end
        end
    end

    // Output decode.
    always_comb begin
        din_ready  = (state_q == IDLE);
        dout_valid = (state_q == DONE);
        dout_r     = dout_r_q;
`ifdef GF151_INV_CHECK_EN
        dout_err   = err_q;
`endif
    end
endmodule

// File: tb/tb_gf151_inverse.sv
// -----------------------------------------------------------------------------
// tb_gf151_inverse
//
// Directed table of elements with hand-computed inverses, followed by
// backpressure, mid-operation reset and a full sweep of 1..150 against a
// brute-force inverse search.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_gf151_inverse;
`ifdef GF151_INV_CHECK_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] din_a;
    logic       dout_valid;
    logic       dout_ready;
    logic [7:0] dout_r;
`ifdef GF151_INV_CHECK_EN
    logic       dout_err;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] r;
        logic       err;
    } vec_t;

    vec_t vecs [8];

    gf151_inverse dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_a      (din_a),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
`ifdef GF151_INV_CHECK_EN
        .dout_err   (dout_err),
`endif
        .dout_r     (dout_r)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Brute-force inverse: independent of the square-and-multiply path.
    function automatic int refInv(input int a);
        for (int r = 1; r < 151; r++)
            if ((a * r) % 151 == 1) return r;
        return 0;
    endfunction

    // Hand one element to the DUT and wait for dout_valid; returns the result
    // and the number of edges from acceptance to dout_valid.
    task automatic applyStimulus(input logic [7:0] a, output logic [7:0] r, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!din_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: din_ready stuck low for a=%0d", a);
        end
        din_valid = 1'b1;
        din_a     = a;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        lat = 0;
        while (!dout_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = dout_r;
    endtask

    // Retire the current result in one cycle.
    task automatic retireNow();
        @(negedge clk);
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
    endtask

    // Retire with a randomly toggling consumer.
    task automatic retireRandom();
        int g;
        g = 0;
        while (dout_valid && g < 200) begin
            @(negedge clk);
            dout_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            g++;
        end
        dout_ready = 1'b0;
        if (g >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL retire_timeout: dout_valid never dropped");
        end
    endtask

    initial begin
        logic [7:0] r;
        int         lat;
        int         bad;
        int         badReady;

        vecs[0] = '{a: 8'd1,   r: 8'd1,   err: 1'b0};
        vecs[1] = '{a: 8'd2,   r: 8'd76,  err: 1'b0};
        vecs[2] = '{a: 8'd3,   r: 8'd101, err: 1'b0};
        vecs[3] = '{a: 8'd150, r: 8'd150, err: 1'b0};
        vecs[4] = '{a: 8'd153, r: 8'd76,  err: 1'b0};
        vecs[5] = '{a: 8'd255, r: 8'd106, err: 1'b0};
        vecs[6] = '{a: 8'd0,   r: 8'd0,   err: 1'b1};
        vecs[7] = '{a: 8'd151, r: 8'd0,   err: 1'b1};

        rst_n      = 1'b0;
        din_valid  = 1'b0;
        din_a      = 8'd0;
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_din_ready", din_ready, 1);
        checkOutput("reset_dout_valid", dout_valid, 0);
        checkOutput("reset_dout_r", dout_r, 0);
`ifdef GF151_INV_CHECK_EN
        checkOutput("reset_dout_err", dout_err, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, r, lat);
            checkOutput($sformatf("vec%0d_latency", i), lat, LAT);
            checkOutput($sformatf("vec%0d_result a=%0d", i, vecs[i].a), r, vecs[i].r);
`ifdef GF151_INV_CHECK_EN
            checkOutput($sformatf("vec%0d_err", i), dout_err, vecs[i].err);
`endif
            if (vecs[i].a == 8'd255)
                checkOutput("inv104_product", (104 * int'(r)) % 151, 1);
            retireNow();
            checkOutput($sformatf("vec%0d_retired", i), dout_valid, 0);
            checkOutput($sformatf("vec%0d_ready_after", i), din_ready, 1);
        end

        // Backpressure: result held, input pulses ignored.
        applyStimulus(8'd3, r, lat);
        bad      = 0;
        badReady = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            din_valid = (i % 3 == 0);
            din_a     = 8'd5;
            @(posedge clk);
            #1;
            if (!dout_valid || dout_r != 8'd101) bad++;
            if (din_ready) badReady++;
        end
        @(negedge clk);
        din_valid = 1'b0;
        checkOutput("bp_stable_violations", bad, 0);
        checkOutput("bp_ready_violations", badReady, 0);
        retireNow();
        checkOutput("bp_retired", dout_valid, 0);
        checkOutput("bp_ready_after", din_ready, 1);
        bad = 0;
        repeat (LAT + 3) begin
            @(posedge clk);
            #1;
            if (dout_valid || !din_ready) bad++;
        end
        checkOutput("bp_pulses_ignored", bad, 0);

        // Reset during op cycle 5.
        @(negedge clk);
        din_valid = 1'b1;
        din_a     = 8'd9;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_dout_valid", dout_valid, 0);
        checkOutput("midrst_dout_r", dout_r, 0);
        checkOutput("midrst_din_ready", din_ready, 1);
`ifdef GF151_INV_CHECK_EN
        checkOutput("midrst_dout_err", dout_err, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (dout_valid) bad++;
        end
        checkOutput("midrst_no_output", bad, 0);
        applyStimulus(8'd7, r, lat);
        checkOutput("midrst_latency", lat, LAT);
        checkOutput("midrst_inv7", r, 108);
        retireNow();

        // Full sweep with a random consumer.
        for (int a = 1; a <= 150; a++) begin
            applyStimulus(8'(a), r, lat);
            checkOutput($sformatf("sweep_latency a=%0d", a), lat, LAT);
            checkOutput($sformatf("sweep_result a=%0d", a), r, refInv(a));
`ifdef GF151_INV_CHECK_EN
            checkOutput($sformatf("sweep_err a=%0d", a), dout_err, 0);
`endif
            retireRandom();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
